// File: rtl/ac1_ctrl.sv
// rtl/ac1_ctrl.sv - AC1 accumulator sequencer: MSB-first shift-and-add over popcount beats
// Optional signed first plane: define AC1_CTRL_SIGNED_EN.
module ac1_ctrl #(
  parameter int M = 16,
  parameter int BITS = 8,
  localparam int PW = $clog2(M) + 1,
  localparam int NW = $clog2(BITS) + 1,
  localparam int ACC_W = $clog2(M) + BITS + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [NW-1:0]    nbits,
  input  logic             ba_valid,
  input  logic [PW-1:0]    ba_data,
  output logic             ba_ready,
  output logic             res_valid,
  output logic [ACC_W-1:0] res_data,
  input  logic             res_ready,
  output logic             busy,
  output logic             err
);

  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

  state_t           state_q, state_d;
  logic [ACC_W-1:0] acc_q;
  logic [NW-1:0]    cnt_q;
  logic [NW-1:0]    nb_q;
  logic             err_q;
  logic             legal;
  logic             beat;
  logic             last;
  logic             accepting;
  logic             load;

  assign legal = (nbits != '0) && (nbits <= NW'(BITS));
  assign beat  = (state_q == ACC) && ba_valid;
  assign last  = (cnt_q == nb_q - NW'(1));

  // start is only looked at in IDLE or while the result is being taken
  always_comb begin
    state_d   = state_q;
    accepting = 1'b0;
    load      = 1'b0;
    case (state_q)
      IDLE: begin
        accepting = 1'b1;
        if (start && legal) begin
          state_d = ACC;
          load    = 1'b1;
        end
      end
      ACC: begin
        if (beat && last) state_d = DONE;
      end
      DONE: begin
        if (res_ready) begin
          accepting = 1'b1;
          if (start && legal) begin
            state_d = ACC;
            load    = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q <= '0;
      cnt_q <= '0;
      nb_q  <= '0;
      err_q <= 1'b0;
    end else begin
      err_q <= accepting && start && !legal;
      if (load) begin
        acc_q <= '0;
        cnt_q <= '0;
        nb_q  <= nbits;
      end else if (beat) begin
        cnt_q <= cnt_q + NW'(1);
`ifdef AC1_CTRL_SIGNED_EN
        // MSB plane carries negative weight in two's complement
        if (cnt_q == '0) acc_q <= '0 - ACC_W'(ba_data);
        else             acc_q <= {acc_q[ACC_W-2:0], 1'b0} + ACC_W'(ba_data);
`else
        acc_q <= {acc_q[ACC_W-2:0], 1'b0} + ACC_W'(ba_data);
`endif
      end
    end
  end

  assign ba_ready  = (state_q == ACC);
  assign res_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign res_data  = acc_q;
  assign err       = err_q;

endmodule
